// File: rtl/pixel_col_window_pkg.sv
// rtl/pixel_col_window_pkg.sv - shared types and constants for the 3x1 column window
package pixel_col_window_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2
  } win_state_t;

  localparam int WIN      = 3;
  localparam int SLOT_CUR = 0;
  localparam int SLOT_UP1 = 1;
  localparam int SLOT_UP2 = 2;

endpackage

// File: rtl/pixel_line_ram.sv
// rtl/pixel_line_ram.sv - simple dual-port line RAM, synchronous 1-cycle read
module pixel_line_ram #(
  parameter int dataW = 8,
  parameter int depth = 640,
  parameter int aW    = 10
) (
  input  logic             clk,
  input  logic             rd_en,
  input  logic [aW-1:0]    rd_addr,
  output logic [dataW-1:0] rd_data,
  input  logic             wr_en,
  input  logic [aW-1:0]    wr_addr,
  input  logic [dataW-1:0] wr_data
);

  logic [dataW-1:0] mem [depth];

  // Contents are deliberately not reset; every row is rewritten before use.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/pixel_col_window.sv
// rtl/pixel_col_window.sv - raster stream to vertical 3x1 pixel columns via two line buffers
module pixel_col_window
  import pixel_col_window_pkg::*;
#(
  parameter int dataW = 8,
  parameter int imgW  = 640,
  parameter int imgH  = 480,
  parameter int xW    = 10,
  parameter int yW    = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [dataW-1:0]     pixIn,
  input  logic                 pixValid,
  input  logic                 sof,
  output logic [WIN*dataW-1:0] PixCol3x1,
  output logic                 colValid,
  output logic [xW-1:0]        colX,
  output logic [yW-1:0]        colY,
  output logic                 eof
);

  localparam logic [xW-1:0] X_LAST   = xW'(imgW - 1);
  localparam logic [yW-1:0] Y_LAST   = yW'(imgH - 1);
  localparam logic [yW-1:0] Y_STREAM = yW'(2);

  win_state_t state;
  logic [xW-1:0] x;
  logic [yW-1:0] y;

  logic          take;
  logic          restart;
  logic [xW-1:0] cur_x;
  logic [yW-1:0] cur_y;
  logic          cur_last;

  // A sof pixel is always (0,0), whatever the counters say.
  assign restart  = pixValid && sof;
  assign take     = pixValid && (sof || state != ST_IDLE);
  assign cur_x    = restart ? '0 : x;
  assign cur_y    = restart ? '0 : y;
  assign cur_last = (cur_x == X_LAST) && (cur_y == Y_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      x     <= '0;
      y     <= '0;
    end else if (take) begin
      x <= (cur_x == X_LAST) ? '0 : cur_x + 1'b1;
      if (cur_x == X_LAST) y <= (cur_y == Y_LAST) ? '0 : cur_y + 1'b1;
      else                 y <= cur_y;
      if (cur_last)                state <= ST_IDLE;
      else if (cur_y >= Y_STREAM)  state <= ST_STREAM;
      else                         state <= ST_FILL;
    end
  end

  logic             s1_valid;
  logic             s1_emit;
  logic             s1_eof;
  logic [dataW-1:0] s1_pix;
  logic [xW-1:0]    s1_x;
  logic [yW-1:0]    s1_y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_emit  <= 1'b0;
      s1_eof   <= 1'b0;
      s1_pix   <= '0;
      s1_x     <= '0;
      s1_y     <= '0;
    end else begin
      s1_valid <= take;
      s1_emit  <= take && (cur_y >= Y_STREAM);
      s1_eof   <= take && cur_last;
      if (take) begin
        s1_pix <= pixIn;
        s1_x   <= cur_x;
        s1_y   <= cur_y;
      end
    end
  end

  logic [dataW-1:0] a_rd;
  logic [dataW-1:0] b_rd;

  // Write-back one cycle after the read lets lineB take lineA's old value at the same x.
  pixel_line_ram #(.dataW(dataW), .depth(imgW), .aW(xW)) u_line_a (
    .clk(clk), .rd_en(take), .rd_addr(cur_x), .rd_data(a_rd),
    .wr_en(s1_valid), .wr_addr(s1_x), .wr_data(s1_pix)
  );

  pixel_line_ram #(.dataW(dataW), .depth(imgW), .aW(xW)) u_line_b (
    .clk(clk), .rd_en(take), .rd_addr(cur_x), .rd_data(b_rd),
    .wr_en(s1_valid), .wr_addr(s1_x), .wr_data(a_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      colValid  <= 1'b0;
      eof       <= 1'b0;
      PixCol3x1 <= '0;
      colX      <= '0;
      colY      <= '0;
    end else begin
      colValid <= s1_emit;
      eof      <= s1_emit && s1_eof;
      if (s1_emit) begin
        PixCol3x1[SLOT_CUR*dataW +: dataW] <= s1_pix;
        PixCol3x1[SLOT_UP1*dataW +: dataW] <= a_rd;
        PixCol3x1[SLOT_UP2*dataW +: dataW] <= b_rd;
        colX <= s1_x;
        colY <= s1_y;
      end
    end
  end

endmodule

// File: tb/tb_pixel_col_window.sv
// tb/tb_pixel_col_window.sv - scoreboard bench for pixel_col_window at 4x4
module tb_pixel_col_window;
  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int XW = 2;
  localparam int YW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            pixValid = 1'b0;
  logic            sof = 1'b0;
  logic [DW-1:0]   pixIn = '0;
  logic [3*DW-1:0] PixCol3x1;
  logic            colValid;
  logic            eof;
  logic [XW-1:0]   colX;
  logic [YW-1:0]   colY;

  typedef struct {
    int          x;
    int          y;
    logic [23:0] col;
    logic        last;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pixel_col_window #(.dataW(DW), .imgW(W), .imgH(H), .xW(XW), .yW(YW)) dut (
    .clk(clk), .rst(rst), .pixIn(pixIn), .pixValid(pixValid), .sof(sof),
    .PixCol3x1(PixCol3x1), .colValid(colValid), .colX(colX), .colY(colY), .eof(eof)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] pv(input logic [7:0] base, input int x, input int y);
    return base + 8'(16 * y + x);
  endfunction

  task automatic drive(input logic v, input logic s, input logic [7:0] p);
    @(posedge clk);
    #1;
    pixValid = v;
    sof      = s;
    pixIn    = p;
  endtask

  // Sends the first n pixels of a frame; columns for indices below push_lim are expected.
  task automatic send_range(input logic [7:0] base, input int n, input logic gap, input int push_lim);
    exp_t e;
    int   x;
    int   y;
    for (int i = 0; i < n; i++) begin
      x = i % W;
      y = i / W;
      drive(1'b1, i == 0, pv(base, x, y));
      if (y >= 2 && i < push_lim) begin
        e.x    = x;
        e.y    = y;
        e.col  = {pv(base, x, y - 2), pv(base, x, y - 1), pv(base, x, y)};
        e.last = (x == W - 1) && (y == H - 1);
        e.cyc  = cyc + 2;
        q.push_back(e);
      end
      if (gap) drive(1'b0, 1'b0, 8'h00);
    end
  endtask

  task automatic drain(input string tag);
    drive(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 20 && q.size() != 0; i++) drive(1'b0, 1'b0, 8'h00);
    repeat (3) drive(1'b0, 1'b0, 8'h00);
    chk(tag, 32'(q.size()), 32'd0);
    q.delete();
  endtask

  always @(negedge clk) begin
    if (colValid === 1'b1) begin
      if (q.size() == 0) begin
        chk("col_unexpected", 32'(colValid), 32'd0);
      end else begin
        m_e = q.pop_front();
        chk("colX", 32'(colX), 32'(m_e.x));
        chk("colY", 32'(colY), 32'(m_e.y));
        chk("col_data", 32'(PixCol3x1), 32'(m_e.col));
        chk("col_eof", 32'(eof), 32'(m_e.last));
        chk("col_cycle", 32'(cyc), 32'(m_e.cyc));
      end
    end else if (eof !== 1'b0) begin
      chk("eof_stray", 32'(eof), 32'd0);
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_colValid", 32'(colValid), 32'd0);
    chk("rst_eof", 32'(eof), 32'd0);
    chk("rst_col", 32'(PixCol3x1), 32'd0);
    chk("rst_colX", 32'(colX), 32'd0);
    chk("rst_colY", 32'(colY), 32'd0);
    rst = 1'b0;

    send_range(8'h00, 16, 1'b0, 16);
    drain("drain_clean");

    repeat (3) drive(1'b1, 1'b0, 8'hAA);
    send_range(8'h00, 16, 1'b0, 16);
    drain("drain_presof");

    repeat (2) drive(1'b1, 1'b0, 8'h55);
    send_range(8'h00, 16, 1'b1, 16);
    drain("drain_gap");

    send_range(8'h00, 10, 1'b0, 10);
    send_range(8'h80, 16, 1'b0, 16);
    drain("drain_restart");

    send_range(8'h00, 10, 1'b0, 10);
    repeat (3) drive(1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, pv(8'h00, 2, 2));
    @(posedge clk);
    #1;
    rst      = 1'b1;
    pixValid = 1'b0;
    #1;
    chk("midrst_colValid", 32'(colValid), 32'd0);
    chk("midrst_col", 32'(PixCol3x1), 32'd0);
    chk("midrst_colX", 32'(colX), 32'd0);
    chk("midrst_colY", 32'(colY), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) drive(1'b1, 1'b0, 8'h77);
    send_range(8'h00, 16, 1'b0, 16);
    drain("drain_post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
